exhaustive_vector_checker: RTL and testbench
============================================

EXHAUSTIVE_VECTOR_CHECKER -- requirements
Module: exhaustive_vector_checker

Interface
REQ-001 Parameter N, default 4: number of DUT inputs driven; legal range 1..16.
REQ-002 Parameter HOLD, default 20: clock cycles each vector is held; legal range 1..65535.
REQ-003 Parameter EXPECTED, default 16'hA5C3: 2^N-bit truth table; bit v is the expected DUT output for applied vector value v.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 gray_mode  input  1  sweep order select, latched on accepted start: 0 = binary, 1 = reflected Gray.
REQ-008 dut_out  input  1  DUT response under test.
REQ-009 dut_in  output  N  vector currently applied to the DUT.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high after a sweep completes; held until the next accepted start or reset.
REQ-012 pass  output  1  equals done AND (err_count == 0).
REQ-013 err_count  output  N+1  number of mismatching vectors in the current or last sweep.
REQ-014 first_err_valid  output  1  high once at least one mismatch has been recorded.
REQ-015 first_err_vec  output  N  applied vector value of the first mismatch.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN when start=1 at a clock edge; DONE -> RUN on the same condition; start in RUN SHALL be ignored.
REQ-018 An accepted start SHALL clear err_count, first_err_valid, first_err_vec and done, latch gray_mode, and zero the index and hold counters.
REQ-019 Internal index i SHALL count 0..2^N-1; dut_in = i in binary mode and i ^ (i >> 1) in Gray mode.
REQ-020 Start accepted at edge k: busy=1 and dut_in = applied vector 0 from cycle k+1; vector i SHALL occupy cycles k+1+i*HOLD through k+(i+1)*HOLD.
REQ-021 dut_out SHALL be sampled only on the last hold cycle of each vector (hold counter == HOLD-1) and compared against EXPECTED[dut_in].
REQ-022 On mismatch err_count increments by 1; if first_err_valid=0, first_err_vec <= dut_in and first_err_valid <= 1 in the same edge.
REQ-023 err_count width N+1 SHALL hold 2^N without wrap; no saturation logic is required.
REQ-024 After the sample of index 2^N-1: RUN -> DONE, busy=0, done=1 from cycle k+1+2^N*HOLD; total run time is exactly 2^N*HOLD cycles.
REQ-025 The index counter SHALL NOT wrap to 0 inside RUN; the last vector remains on dut_in in DONE until restart.
REQ-026 HOLD=1 SHALL sample every cycle, with one vector per cycle and no gaps.
REQ-027 In IDLE, dut_in SHALL be 0; in DONE, err_count and the first_err outputs SHALL hold their values.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, and latched gray_mode=0.
REQ-029 rst SHALL take priority over start at the same edge.
REQ-030 Reset during RUN SHALL abort the sweep with no done pulse; a later start begins a fresh sweep from vector 0.

Verification
REQ-031 Golden DUT model (dut_out = EXPECTED[dut_in]), N=4, HOLD=20, binary mode, start at edge k -> 16 vectors 0..15 each held 20 cycles; done=1 at cycle k+321, err_count=0, pass=1.
REQ-032 Model with output inverted only for vector 5 -> err_count=1, first_err_valid=1, first_err_vec=5, pass=0.
REQ-033 dut_out stuck at 0 -> err_count=8 (popcount of 16'hA5C3), first_err_vec=0; stuck at 1 -> err_count=8, first_err_vec=2.
REQ-034 gray_mode=1 at start -> dut_in sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; golden model gives pass=1; toggling gray_mode mid-run has no effect.
REQ-035 Reset at vector 7 mid-run -> all outputs at reset values on the next cycle; a subsequent start gives a full 320-cycle sweep; start pulses during RUN do not restart or extend the sweep.
REQ-036 HOLD=1 build -> done at cycle k+17; a second start in DONE clears err_count and reruns the sweep.

Source files
------------

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive stimulus sweeper: drives every N-bit vector (binary or Gray order),
// holds each for HOLD cycles and scores the DUT response against a truth table.
module exhaustive_vector_checker #(
    parameter int                N        = 4,
    parameter int                HOLD     = 20,
    parameter logic [(2**N)-1:0] EXPECTED = 16'hA5C3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         gray_mode,
    input  logic         dut_out,
    output logic [N-1:0] dut_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_err_valid,
    output logic [N-1:0] first_err_vec
);

    localparam logic [15:0]  HOLD_LAST = 16'(HOLD - 1);
    localparam logic [N-1:0] IDX_LAST  = '1;
    localparam logic [N-1:0] IDX_ONE   = N'(1);
    localparam logic [N:0]   ERR_ONE   = (N+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [N-1:0] idx;
    logic [15:0]  hold_cnt;
    logic         gray_lat;

    logic [N-1:0] applied;
    logic         accept_start;
    logic         sample;
    logic         last_idx;
    logic         mismatch;

    // A start is only honoured outside a sweep; RUN ignores it completely.
    assign accept_start = start && (state != RUN);
    assign sample       = (state == RUN) && (hold_cnt == HOLD_LAST);
    assign last_idx     = (idx == IDX_LAST);
    assign applied      = gray_lat ? (idx ^ (idx >> 1)) : idx;
    assign mismatch     = sample && (dut_out != EXPECTED[applied]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample && last_idx) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Index stops at the last vector so it stays applied while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            hold_cnt        <= '0;
            gray_lat        <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (accept_start) begin
            idx             <= '0;
            hold_cnt        <= '0;
            gray_lat        <= gray_mode;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (state == RUN) begin
            if (sample) begin
                hold_cnt <= '0;
                if (!last_idx) begin
                    idx <= idx + IDX_ONE;
                end
            end else begin
                hold_cnt <= hold_cnt + 16'd1;
            end
            if (mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_vec   <= applied;
                end
            end
        end
    end

    assign dut_in = (state == IDLE) ? '0 : applied;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed bench for exhaustive_vector_checker: a HOLD=20 build and a HOLD=1 build
// driven by a behavioural DUT model with selectable fault modes.
module tb_exhaustive_vector_checker;

    localparam logic [15:0] TRUTH = 16'hA5C3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_a = 1'b0, gray_a = 1'b0, dut_out_a;
    logic [3:0] dut_in_a, fev_a;
    logic       busy_a, done_a, pass_a, fe_a;
    logic [4:0] err_a;
    int         mode_a = 0;

    logic       start_b = 1'b0, gray_b = 1'b0, dut_out_b;
    logic [3:0] dut_in_b, fev_b;
    logic       busy_b, done_b, pass_b, fe_b;
    logic [4:0] err_b;
    int         mode_b = 0;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    always #5 clk = ~clk;

    exhaustive_vector_checker #(.N(4), .HOLD(20), .EXPECTED(16'hA5C3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .gray_mode(gray_a), .dut_out(dut_out_a),
        .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_valid(fe_a), .first_err_vec(fev_a)
    );

    exhaustive_vector_checker #(.N(4), .HOLD(1), .EXPECTED(16'hA5C3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .gray_mode(gray_b), .dut_out(dut_out_b),
        .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_valid(fe_b), .first_err_vec(fev_b)
    );

    // Mode 0 golden, 1 inverted on vector 5, 2 stuck at 0, 3 stuck at 1.
    function automatic logic model_out(input logic [3:0] v, input int mode);
        logic [15:0] t;
        t = TRUTH;
        case (mode)
            0:       return t[v];
            1:       return (v == 4'd5) ? ~t[v] : t[v];
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign dut_out_a = model_out(dut_in_a, mode_a);
    assign dut_out_b = model_out(dut_in_b, mode_b);

    // Status word: {busy, done, pass, first_err_valid, err_count, first_err_vec, dut_in}.
    function automatic logic [16:0] status_a();
        return {busy_a, done_a, pass_a, fe_a, err_a, fev_a, dut_in_a};
    endfunction

    function automatic logic [16:0] status_b();
        return {busy_b, done_b, pass_b, fe_b, err_b, fev_b, dut_in_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep on the HOLD=20 build and checks every vector's first and last cycle.
    task automatic sweep_a(input logic gray, input bit pulse_start, input bit toggle_gray);
        logic [3:0] exp_vec;
        gray_a  = gray;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int v = 0; v < 16; v++) begin
            for (int h = 0; h < 20; h++) begin
                start_a = (pulse_start && v == 3 && h == 0) ? 1'b1 : 1'b0;
                if (toggle_gray && v == 6 && h == 0) gray_a = ~gray_a;
                exp_vec = gray ? gray_seq[v] : 4'(v);
                if (h == 0 || h == 19) begin
                    n_vec++;
                    if ({busy_a, done_a, dut_in_a} !== {1'b1, 1'b0, exp_vec}) begin
                        n_miss++;
                        $display("[TB] FAIL sweep v%0d h%0d: got busy/done/in %b/%b/%0d want 1/0/%0d",
                                 v, h, busy_a, done_a, dut_in_a, exp_vec);
                    end
                end
                step();
            end
        end
        start_a = 1'b0;
        gray_a  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_vec++;
        if (status_a() !== 17'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_a: got %h want %h", status_a(), 17'd0);
        end
        n_vec++;
        if (status_b() !== 17'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_b: got %h want %h", status_b(), 17'd0);
        end
    endtask

    task automatic test_golden_binary();
        mode_a = 0;
        sweep_a(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0110, 5'd0, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL golden_done: got %h want %h", status_a(), {4'b0110, 5'd0, 4'd0, 4'd15});
        end
        repeat (7) step();
        n_vec++;
        if (status_a() !== {4'b0110, 5'd0, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL golden_hold: got %h want %h", status_a(), {4'b0110, 5'd0, 4'd0, 4'd15});
        end
    endtask

    task automatic test_single_error();
        mode_a = 1;
        sweep_a(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0101, 5'd1, 4'd5, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL single_err: got %h want %h", status_a(), {4'b0101, 5'd1, 4'd5, 4'd15});
        end
    endtask

    task automatic test_stuck();
        mode_a = 2;
        sweep_a(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0101, 5'd8, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL stuck0: got %h want %h", status_a(), {4'b0101, 5'd8, 4'd0, 4'd15});
        end
        mode_a = 3;
        sweep_a(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0101, 5'd8, 4'd2, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL stuck1: got %h want %h", status_a(), {4'b0101, 5'd8, 4'd2, 4'd15});
        end
    endtask

    task automatic test_gray();
        mode_a = 0;
        sweep_a(1'b1, 1'b0, 1'b1);
        n_vec++;
        if (status_a() !== {4'b0110, 5'd0, 4'd0, 4'd8}) begin
            n_miss++;
            $display("[TB] FAIL gray_golden: got %h want %h", status_a(), {4'b0110, 5'd0, 4'd0, 4'd8});
        end
        mode_a = 1;
        sweep_a(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0101, 5'd1, 4'd5, 4'd8}) begin
            n_miss++;
            $display("[TB] FAIL gray_err: got %h want %h", status_a(), {4'b0101, 5'd1, 4'd5, 4'd8});
        end
    endtask

    task automatic test_reset_midrun();
        mode_a  = 2;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (7 * 20 + 5) step();
        n_vec++;
        if (status_a() !== {4'b1001, 5'd3, 4'd0, 4'd7}) begin
            n_miss++;
            $display("[TB] FAIL midrun_pre: got %h want %h", status_a(), {4'b1001, 5'd3, 4'd0, 4'd7});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (status_a() !== 17'd0) begin
            n_miss++;
            $display("[TB] FAIL midrun_reset: got %h want %h", status_a(), 17'd0);
        end
        rst     = 1'b1;
        start_a = 1'b1;
        step();
        rst     = 1'b0;
        start_a = 1'b0;
        repeat (3) step();
        n_vec++;
        if (status_a() !== 17'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_priority: got %h want %h", status_a(), 17'd0);
        end
        mode_a = 0;
        sweep_a(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (status_a() !== {4'b0110, 5'd0, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL rerun_done: got %h want %h", status_a(), {4'b0110, 5'd0, 4'd0, 4'd15});
        end
    endtask

    task automatic test_back_to_back();
        mode_b  = 2;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int v = 0; v < 16; v++) begin
            n_vec++;
            if ({busy_b, done_b, dut_in_b} !== {1'b1, 1'b0, 4'(v)}) begin
                n_miss++;
                $display("[TB] FAIL hold1_a v%0d: got busy/done/in %b/%b/%0d want 1/0/%0d",
                         v, busy_b, done_b, dut_in_b, v);
            end
            step();
        end
        n_vec++;
        if (status_b() !== {4'b0101, 5'd8, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL hold1_stuck0: got %h want %h", status_b(), {4'b0101, 5'd8, 4'd0, 4'd15});
        end
        mode_b  = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n_vec++;
        if (status_b() !== {4'b1000, 5'd0, 4'd0, 4'd0}) begin
            n_miss++;
            $display("[TB] FAIL hold1_restart: got %h want %h", status_b(), {4'b1000, 5'd0, 4'd0, 4'd0});
        end
        for (int v = 0; v < 16; v++) begin
            n_vec++;
            if ({busy_b, dut_in_b} !== {1'b1, 4'(v)}) begin
                n_miss++;
                $display("[TB] FAIL hold1_b v%0d: got busy/in %b/%0d want 1/%0d", v, busy_b, dut_in_b, v);
            end
            step();
        end
        n_vec++;
        if (status_b() !== {4'b0110, 5'd0, 4'd0, 4'd15}) begin
            n_miss++;
            $display("[TB] FAIL hold1_golden: got %h want %h", status_b(), {4'b0110, 5'd0, 4'd0, 4'd15});
        end
    endtask

    initial begin
        $display("[TB] exhaustive_vector_checker bench start");
        test_reset();
        test_golden_binary();
        test_single_error();
        test_stuck();
        test_gray();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
